mux_rr_feeder: RTL and testbench

- Upstream feeder for the 3-input 4-bit select mux.
- Accepts words from three independent sources (A, B, C), each into its own one-entry holding register.
- Round-robin schedules the occupied entries onto the mux by driving s1/s0 and the held A/B/C buses.
- Presents the selected word to the downstream consumer with a valid/ready handshake.

---
 rtl/mux_rr_feeder.sv | 130 +++++++++++++
 tb/tb_mux_rr_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_feeder.sv
// Feeder for the 3-input select mux: three one-entry source slots scheduled onto s1/s0 with a valid/ready output.
// Define MUX_FIXED_PRIO_EN for fixed C > B > A selection instead of round-robin.
module mux_rr_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_req,
  output logic             a_rdy,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_req,
  output logic             b_rdy,
  input  logic [WIDTH-1:0] c_in,
  input  logic             c_req,
  output logic             c_rdy,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       full_q, full_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] aData_q, bData_q, cData_q;
  logic [2:0]       capture;
  logic [2:0]       grantMask;
  logic [2:0]       remaining;
  logic [1:0]       idlePick;
  logic [1:0]       presentPick;

  // Slot index doubles as the select code: 0 = A (00), 1 = B (01), 2 = C (10).
  assign capture   = {c_req & ~full_q[2], b_req & ~full_q[1], a_req & ~full_q[0]};
  assign grantMask = 3'b001 << sel_q;
  assign remaining = full_q & ~grantMask;

`ifdef MUX_FIXED_PRIO_EN
  function automatic logic [1:0] pickNext(input logic [2:0] mask);
    return mask[2] ? 2'd2 : (mask[1] ? 2'd1 : 2'd0);
  endfunction

  assign idlePick    = pickNext(full_q);
  assign presentPick = pickNext(remaining);
`else
  logic [1:0] lastGrant_q, lastGrant_d;

  // First occupied slot strictly after ptr in A -> B -> C -> A order.
  function automatic logic [1:0] pickNext(input logic [2:0] mask, input logic [1:0] ptr);
    case (ptr)
      2'd0:    return mask[1] ? 2'd1 : (mask[2] ? 2'd2 : 2'd0);
      2'd1:    return mask[2] ? 2'd2 : (mask[0] ? 2'd0 : 2'd1);
      default: return mask[0] ? 2'd0 : (mask[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

  assign idlePick    = pickNext(full_q, lastGrant_q);
  assign presentPick = pickNext(remaining, sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastGrant_q <= 2'd2;
    else        lastGrant_q <= lastGrant_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q  <= 3'b000;
      sel_q   <= 2'd0;
      aData_q <= '0;
      bData_q <= '0;
      cData_q <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      sel_q   <= sel_d;
      if (capture[0]) aData_q <= a_in;
      if (capture[1]) bData_q <= b_in;
      if (capture[2]) cData_q <= c_in;
    end
  end

  // Selection only looks at pre-edge occupancy, so a same-edge capture waits one cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    full_d  = full_q | capture;
`ifndef MUX_FIXED_PRIO_EN
    lastGrant_d = lastGrant_q;
`endif
    case (state_q)
      IDLE: begin
        if (|full_q) begin
          sel_d   = idlePick;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          full_d = (full_q & ~grantMask) | capture;
`ifndef MUX_FIXED_PRIO_EN
          lastGrant_d = sel_q;
`endif
          if (|remaining) sel_d = presentPick;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == PRESENT);
    s1        = sel_q[1];
    s0        = sel_q[0];
    a_rdy     = ~full_q[0];
    b_rdy     = ~full_q[1];
    c_rdy     = ~full_q[2];
    A         = aData_q;
    B         = bData_q;
    C         = cData_q;
  end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Scoreboard bench for mux_rr_feeder: expected grants are queued at stimulus time and popped on each output handshake.
module tb_mux_rr_feeder;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a_in, b_in, c_in;
  logic             a_req, b_req, c_req;
  logic             a_rdy, b_rdy, c_rdy;
  logic             out_ready, out_valid, s1, s0;
  logic [WIDTH-1:0] A, B, C;

  exp_t sbQueue[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_rr_feeder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_in(a_in), .a_req(a_req), .a_rdy(a_rdy),
    .b_in(b_in), .b_req(b_req), .b_rdy(b_rdy),
    .c_in(c_in), .c_req(c_req), .c_rdy(c_rdy),
    .out_ready(out_ready), .out_valid(out_valid),
    .s1(s1), .s0(s0), .A(A), .B(B), .C(C)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    {a_req, b_req, c_req, out_ready} = 4'b0000;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sbQueue.delete();
    tick();
  endtask

  // Pops one expected word for every accepted handshake seen mid-cycle.
  task automatic monitor();
    exp_t             e;
    logic [WIDTH-1:0] got;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = ({s1, s0} == 2'b00) ? A : (({s1, s0} == 2'b01) ? B : C);
        checks++;
        if (sbQueue.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_unexpected: got sel=%b data=%h, required no grant", {s1, s0}, got);
        end else begin
          e = sbQueue.pop_front();
          if ({s1, s0} !== e.sel || got !== e.data) begin
            failures++;
            $display("[TB] FAIL sb_grant: got sel=%b data=%h, required sel=%b data=%h", {s1, s0}, got, e.sel, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {a_req, b_req, c_req, out_ready} = 4'b0000;
    a_in = '0; b_in = '0; c_in = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if ({s1, s0} !== 2'b00) begin failures++; $display("[TB] FAIL reset_sel: got %b required 00", {s1, s0}); end
    checks++; if ({A, B, C} !== 12'h000) begin failures++; $display("[TB] FAIL reset_data: got %h required 000", {A, B, C}); end
    checks++; if ({a_rdy, b_rdy, c_rdy} !== 3'b111) begin failures++; $display("[TB] FAIL reset_rdy: got %b required 111", {a_rdy, b_rdy, c_rdy}); end
    #20 rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid: got %b required 0", out_valid); end
    checks++; if ({a_rdy, b_rdy, c_rdy} !== 3'b111) begin failures++; $display("[TB] FAIL idle_rdy: got %b required 111", {a_rdy, b_rdy, c_rdy}); end
  endtask

  task automatic test_single();
    b_in = 4'h9; b_req = 1'b1; out_ready = 1'b1;
    sbQueue.push_back('{sel: 2'b01, data: 4'h9});
    tick();
    b_req = 1'b0;
    checks++; if (b_rdy !== 1'b0) begin failures++; $display("[TB] FAIL single_full: got b_rdy=%b required 0", b_rdy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_latency: got out_valid=%b required 0", out_valid); end
    tick();
    checks++; if ({out_valid, s1, s0} !== 3'b101) begin failures++; $display("[TB] FAIL single_present: got v/s1/s0=%b required 101", {out_valid, s1, s0}); end
    checks++; if (B !== 4'h9) begin failures++; $display("[TB] FAIL single_data: got B=%h required 9", B); end
    tick();
    checks++; if ({b_rdy, out_valid} !== 2'b10) begin failures++; $display("[TB] FAIL single_done: got rdy/valid=%b required 10", {b_rdy, out_valid}); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] order [3];
`ifdef MUX_FIXED_PRIO_EN
    order = '{2'd2, 2'd1, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2};
`endif
    resetPulse();
    a_in = 4'h3; b_in = 4'h5; c_in = 4'h7;
    {a_req, b_req, c_req, out_ready} = 4'b1111;
    for (int i = 0; i < 3; i++)
      sbQueue.push_back('{sel: order[i], data: (order[i] == 2'd0) ? 4'h3 : ((order[i] == 2'd1) ? 4'h5 : 4'h7)});
    tick();
    {a_req, b_req, c_req} = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, s1, s0} !== {1'b1, order[i]}) begin
        failures++;
        $display("[TB] FAIL rr_grant%0d: got v/s1/s0=%b required %b", i, {out_valid, s1, s0}, {1'b1, order[i]});
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle: got out_valid=%b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    c_in = 4'hE; c_req = 1'b1;
    sbQueue.push_back('{sel: 2'b10, data: 4'hE});
    tick();
    c_req = 1'b0;
    tick();
    a_in = 4'h1; a_req = 1'b1;
    sbQueue.push_back('{sel: 2'b00, data: 4'h1});
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, s1, s0, c_rdy} !== 4'b1100 || C !== 4'hE) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got v/s1/s0/c_rdy=%b C=%h required 1100 C=e", i, {out_valid, s1, s0, c_rdy}, C);
      end
      tick();
      a_req = 1'b0;
    end
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_a_captured: got a_rdy=%b required 0", a_rdy); end
    out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, s1, s0, c_rdy} !== 4'b1001 || A !== 4'h1) begin failures++; $display("[TB] FAIL bp_next: got v/s1/s0/c_rdy=%b A=%h required 1001 A=1", {out_valid, s1, s0, c_rdy}, A); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle: got out_valid=%b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    b_in = 4'h6; b_req = 1'b1; out_ready = 1'b0;
    tick();
    b_req = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ar_present: got out_valid=%b required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, b_rdy} !== 2'b01) begin failures++; $display("[TB] FAIL ar_clear: got valid/b_rdy=%b required 01", {out_valid, b_rdy}); end
    checks++; if ({A, B, C} !== 12'h000) begin failures++; $display("[TB] FAIL ar_data: got %h required 000", {A, B, C}); end
    sbQueue.delete();
    #1 rst_n = 1'b1;
    tick();
  endtask

`ifdef MUX_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    resetPulse();
    a_in = 4'h2; c_in = 4'h8;
    {a_req, c_req, out_ready} = 3'b111;
    sbQueue.push_back('{sel: 2'b10, data: 4'h8});
    sbQueue.push_back('{sel: 2'b00, data: 4'h2});
    tick();
    {a_req, c_req} = 2'b00;
    tick();
    checks++; if ({s1, s0} !== 2'b10) begin failures++; $display("[TB] FAIL fp_first: got %b required 10", {s1, s0}); end
    tick();
    checks++; if ({s1, s0} !== 2'b00) begin failures++; $display("[TB] FAIL fp_second: got %b required 00", {s1, s0}); end
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef MUX_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    repeat (2) tick();
    checks++;
    if (sbQueue.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d words still expected, required 0", sbQueue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
